// File: rtl/difftest_pkg.sv
// Shared types and constants for the difftest commit tracker.
package difftest_pkg;

    localparam int NR_DIFF_REG = 33;
    localparam int DIFF_PC_IDX = 32;
    localparam int DIFF_XLEN   = 64;

    typedef struct packed {
        logic [DIFF_XLEN-1:0] pc;
        logic [31:0]          inst;
        logic [4:0]           rd;
        logic                 wen;
        logic [DIFF_XLEN-1:0] wdata;
        logic [DIFF_XLEN-1:0] next_pc;
        logic                 skip;
    } commit_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HANG = 1'b1
    } wdt_state_e;

endpackage

// File: rtl/commit_fifo.sv
// In-order synchronous FIFO of commit entries; full/empty are registered so
// downstream handshake outputs come straight from flops.
module commit_fifo
    import difftest_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  commit_entry_t    wr_data_i,
    input  logic             pop_i,
    output commit_entry_t    rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    commit_entry_t    mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage needs no reset: pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign count_o   = count_q;

endmodule

// File: rtl/difftest_commit_tracker.sv
// Buffers retire events, hands them to the difftest consumer in order, and
// keeps a shadow GPR/PC image that tracks the last consumed commit.
module difftest_commit_tracker
    import difftest_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [63:0] RESET_PC   = 64'h8000_0000,
    parameter int unsigned WDT_LIMIT  = 4096
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic [XLEN-1:0] wb_pc,
    input  logic [31:0]     wb_inst,
    input  logic [4:0]      wb_rd,
    input  logic            wb_wen,
    input  logic [XLEN-1:0] wb_wdata,
    input  logic [XLEN-1:0] wb_next_pc,
    input  logic            wb_skip,
    output logic            cmt_valid,
    input  logic            cmt_ready,
    output logic [XLEN-1:0] cmt_pc,
    output logic [31:0]     cmt_inst,
    output logic            cmt_skip,
    output logic [XLEN-1:0] difftest_gpr_0,
    output logic [XLEN-1:0] difftest_gpr_1,
    output logic [XLEN-1:0] difftest_gpr_2,
    output logic [XLEN-1:0] difftest_gpr_3,
    output logic [XLEN-1:0] difftest_gpr_4,
    output logic [XLEN-1:0] difftest_gpr_5,
    output logic [XLEN-1:0] difftest_gpr_6,
    output logic [XLEN-1:0] difftest_gpr_7,
    output logic [XLEN-1:0] difftest_gpr_8,
    output logic [XLEN-1:0] difftest_gpr_9,
    output logic [XLEN-1:0] difftest_gpr_10,
    output logic [XLEN-1:0] difftest_gpr_11,
    output logic [XLEN-1:0] difftest_gpr_12,
    output logic [XLEN-1:0] difftest_gpr_13,
    output logic [XLEN-1:0] difftest_gpr_14,
    output logic [XLEN-1:0] difftest_gpr_15,
    output logic [XLEN-1:0] difftest_gpr_16,
    output logic [XLEN-1:0] difftest_gpr_17,
    output logic [XLEN-1:0] difftest_gpr_18,
    output logic [XLEN-1:0] difftest_gpr_19,
    output logic [XLEN-1:0] difftest_gpr_20,
    output logic [XLEN-1:0] difftest_gpr_21,
    output logic [XLEN-1:0] difftest_gpr_22,
    output logic [XLEN-1:0] difftest_gpr_23,
    output logic [XLEN-1:0] difftest_gpr_24,
    output logic [XLEN-1:0] difftest_gpr_25,
    output logic [XLEN-1:0] difftest_gpr_26,
    output logic [XLEN-1:0] difftest_gpr_27,
    output logic [XLEN-1:0] difftest_gpr_28,
    output logic [XLEN-1:0] difftest_gpr_29,
    output logic [XLEN-1:0] difftest_gpr_30,
    output logic [XLEN-1:0] difftest_gpr_31,
    output logic [XLEN-1:0] difftest_gpr_32,
    output logic [63:0]     instret,
    output logic            hang
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned WDT_W = $clog2(WDT_LIMIT + 1);

    commit_entry_t    wr_entry;
    commit_entry_t    head;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             do_pop;

    logic [XLEN-1:0]  gpr_q [NR_DIFF_REG];
    logic [XLEN-1:0]  gpr_d [NR_DIFF_REG];
    logic [63:0]      instret_q, instret_d;
    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
    wdt_state_e       wdt_state_q, wdt_state_d;

    always_comb begin
        wr_entry         = '0;
        wr_entry.pc      = DIFF_XLEN'(wb_pc);
        wr_entry.inst    = wb_inst;
        wr_entry.rd      = wb_rd;
        wr_entry.wen     = wb_wen;
        wr_entry.wdata   = DIFF_XLEN'(wb_wdata);
        wr_entry.next_pc = DIFF_XLEN'(wb_next_pc);
        wr_entry.skip    = wb_skip;
    end

    commit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (wb_valid),
        .wr_data_i (wr_entry),
        .pop_i     (cmt_ready),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign wb_ready  = !fifo_full;
    assign cmt_valid = !fifo_empty;
    assign do_pop    = cmt_valid && cmt_ready;
    assign cmt_pc    = XLEN'(head.pc);
    assign cmt_inst  = head.inst;
    assign cmt_skip  = head.skip;

    // Shadow image only moves on a consumed commit, so it always matches the
    // last entry the consumer has seen.
    always_comb begin
        gpr_d     = gpr_q;
        instret_d = instret_q;
        if (do_pop) begin
            if (head.wen && (head.rd != '0)) begin
                gpr_d[{1'b0, head.rd}] = XLEN'(head.wdata);
            end
            gpr_d[DIFF_PC_IDX] = XLEN'(head.next_pc);
            instret_d          = instret_q + 64'd1;
        end
    end

    always_comb begin
        wdt_cnt_d   = wdt_cnt_q;
        wdt_state_d = wdt_state_q;
        if (do_pop) begin
            wdt_cnt_d = '0;
        end else if (wdt_cnt_q != WDT_W'(WDT_LIMIT)) begin
            wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
        end
        if ((wdt_state_q == RUN) && (wdt_cnt_d == WDT_W'(WDT_LIMIT))) begin
            wdt_state_d = HANG;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) begin
                gpr_q[i] <= '0;
            end
            gpr_q[DIFF_PC_IDX] <= XLEN'(RESET_PC);
            instret_q          <= '0;
            wdt_cnt_q          <= '0;
            wdt_state_q        <= RUN;
        end else begin
            gpr_q       <= gpr_d;
            instret_q   <= instret_d;
            wdt_cnt_q   <= wdt_cnt_d;
            wdt_state_q <= wdt_state_d;
        end
    end

    assign instret = instret_q;
    assign hang    = (wdt_state_q == HANG);

    a_full_count : assert property (@(posedge clk) disable iff (!rst_n)
        fifo_full == (fifo_count == CNT_W'(FIFO_DEPTH)));

    assign difftest_gpr_0  = gpr_q[0];
    assign difftest_gpr_1  = gpr_q[1];
    assign difftest_gpr_2  = gpr_q[2];
    assign difftest_gpr_3  = gpr_q[3];
    assign difftest_gpr_4  = gpr_q[4];
    assign difftest_gpr_5  = gpr_q[5];
    assign difftest_gpr_6  = gpr_q[6];
    assign difftest_gpr_7  = gpr_q[7];
    assign difftest_gpr_8  = gpr_q[8];
    assign difftest_gpr_9  = gpr_q[9];
    assign difftest_gpr_10 = gpr_q[10];
    assign difftest_gpr_11 = gpr_q[11];
    assign difftest_gpr_12 = gpr_q[12];
    assign difftest_gpr_13 = gpr_q[13];
    assign difftest_gpr_14 = gpr_q[14];
    assign difftest_gpr_15 = gpr_q[15];
    assign difftest_gpr_16 = gpr_q[16];
    assign difftest_gpr_17 = gpr_q[17];
    assign difftest_gpr_18 = gpr_q[18];
    assign difftest_gpr_19 = gpr_q[19];
    assign difftest_gpr_20 = gpr_q[20];
    assign difftest_gpr_21 = gpr_q[21];
    assign difftest_gpr_22 = gpr_q[22];
    assign difftest_gpr_23 = gpr_q[23];
    assign difftest_gpr_24 = gpr_q[24];
    assign difftest_gpr_25 = gpr_q[25];
    assign difftest_gpr_26 = gpr_q[26];
    assign difftest_gpr_27 = gpr_q[27];
    assign difftest_gpr_28 = gpr_q[28];
    assign difftest_gpr_29 = gpr_q[29];
    assign difftest_gpr_30 = gpr_q[30];
    assign difftest_gpr_31 = gpr_q[31];
    assign difftest_gpr_32 = gpr_q[DIFF_PC_IDX];

endmodule
